// File: rtl/sm_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_debouncer_pkg
//  Description : Shared types and helpers for the push-button / switch
//                debouncer (per-bit filter state, counter width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package sm_debouncer_pkg;

  // Per-bit filter state. It is decoded from the synchronized input versus
  // the accepted level rather than stored, so it can never disagree with them.
  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } db_state_e;

  // Width of a counter that must hold values 0..cycles without wrapping.
  // Clamped to at least one bit so degenerate parameters still elaborate.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage : sm_debouncer_pkg
`default_nettype wire

// File: rtl/sm_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sm_debounce_bit
//  Description : One debounced input: polarity fix, two-flop synchronizer,
//                settle-time counter, accepted level and one-cycle
//                press/release pulses. All outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_debounce_bit
  import sm_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  // Count value at which a mismatch has persisted long enough to be accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             in_w;
  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept_w;
  db_state_e        state_w;

  // Normalise to active-high before anything else sees the input.
  assign in_w = ACTIVE_LOW ? ~raw_i : raw_i;

  // Two-flop synchronizer; only s2_q is trusted downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in_w;
      s2_q <= s1_q;
    end
  end

  // Filter state register: accepted level, settle counter and pulse flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: any cycle where the input agrees with the level clears the
  // count, so a glitch throws away all progress toward acceptance.
  always_comb begin
    state_w   = (s2_q == level_q) ? ST_STABLE : ST_SETTLING;
    accept_w  = 1'b0;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_w)
      ST_STABLE: begin
        cnt_d = '0;
      end
      ST_SETTLING: begin
        if (cnt_q == CNT_LAST) begin
          accept_w  = 1'b1;
          level_d   = s2_q;
          cnt_d     = '0;
          press_d   = accept_w & s2_q;
          release_d = accept_w & ~s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : sm_debounce_bit
`default_nettype wire

// File: rtl/sm_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : sm_debouncer
//  Description : Board input conditioner. WIDTH independent debounced bits,
//                each producing a clean active-high level plus one-cycle
//                press and release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_debouncer
  import sm_debouncer_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o
);

  // One self-contained filter per input bit; bits never interact.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sm_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (raw_i[gi]),
      .level_o   (level_o[gi]),
      .press_o   (press_o[gi]),
      .release_o (release_o[gi])
    );
  end

endmodule : sm_debouncer
`default_nettype wire
